// File: rtl/npu_oq_pack.sv
// npu_oq_pack: output requantize-and-pack stage.
// Adds the output zero point to each scaled result, optionally clamps at the
// zero point (ReLU), saturates to signed Q_LEN bits and packs PACK lanes into
// one registered output word.
// Ports:
//   clk_i, rst_i            clock (rising edge), async active-high reset
//   data_i/valid_i/last_i   scaled input beat, last_i flushes a partial word
//   ready_o                 beat accepted this cycle when valid_i is high
//   zp_i, relu_en_i         per-beat zero point and ReLU enable
//   data_o/keep_o/last_o    packed word, lane-valid mask, row-end flag
//   valid_o, ready_i        output handshake
module npu_oq_pack #(
    parameter int unsigned M_LEN = 32,
    parameter int unsigned PACK  = 4,
    parameter int unsigned Q_LEN = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [M_LEN-1:0]        data_i,
    input  logic                    valid_i,
    input  logic                    last_i,
    output logic                    ready_o,
    input  logic [Q_LEN-1:0]        zp_i,
    input  logic                    relu_en_i,
    output logic [PACK*Q_LEN-1:0]   data_o,
    output logic [PACK-1:0]         keep_o,
    output logic                    last_o,
    output logic                    valid_o,
    input  logic                    ready_i
);

    localparam int unsigned CNT_W  = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int unsigned SUM_W  = M_LEN + 1;
    localparam int unsigned WORD_W = PACK * Q_LEN;

    localparam logic signed [SUM_W-1:0] SUM_MAX = SUM_W'((2 ** (Q_LEN - 1)) - 1);
    localparam logic signed [SUM_W-1:0] SUM_MIN = ~SUM_MAX;
    localparam logic [Q_LEN-1:0]        LANE_MAX = {1'b0, {(Q_LEN - 1){1'b1}}};
    localparam logic [Q_LEN-1:0]        LANE_MIN = ~LANE_MAX;

    logic [CNT_W-1:0]        cnt;
    logic [WORD_W-1:0]       pack_buf;
    logic [PACK-1:0]         buf_keep;

    logic                    accept;
    logic                    close;
    logic signed [SUM_W-1:0] data_ext;
    logic signed [SUM_W-1:0] zp_ext;
    logic signed [SUM_W-1:0] sum;
    logic [Q_LEN-1:0]        q;
    logic [WORD_W-1:0]       buf_merged;
    logic [PACK-1:0]         keep_merged;

    // Output register either empty or draining this cycle.
    assign ready_o = !valid_o || ready_i;
    assign accept  = valid_i && ready_o;
    assign close   = (cnt == CNT_W'(PACK - 1)) || last_i;

    // Zero point, optional ReLU at the zero point, saturation to Q_LEN bits.
    always_comb begin
        data_ext = {data_i[M_LEN-1], data_i};
        zp_ext   = {{(SUM_W - Q_LEN){zp_i[Q_LEN-1]}}, zp_i};
        sum      = data_ext + zp_ext;
        if (relu_en_i && (sum < zp_ext)) begin
            sum = zp_ext;
        end
        if (sum > SUM_MAX) begin
            q = LANE_MAX;
        end else if (sum < SUM_MIN) begin
            q = LANE_MIN;
        end else begin
            q = sum[Q_LEN-1:0];
        end
    end

    // Current beat merged into the pack buffer at lane cnt.
    always_comb begin
        buf_merged  = pack_buf;
        keep_merged = buf_keep;
        for (int unsigned n = 0; n < PACK; n++) begin
            if (cnt == CNT_W'(n)) begin
                buf_merged[n*Q_LEN +: Q_LEN] = q;
                keep_merged[n]               = 1'b1;
            end
        end
    end

    // Pack buffer, lane counter and output word register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt      <= '0;
            pack_buf <= '0;
            buf_keep <= '0;
            data_o   <= '0;
            keep_o   <= '0;
            last_o   <= 1'b0;
            valid_o  <= 1'b0;
        end else if (accept && close) begin
            // ready_o guarantees the output register is free or draining.
            data_o   <= buf_merged;
            keep_o   <= keep_merged;
            last_o   <= last_i;
            valid_o  <= 1'b1;
            cnt      <= '0;
            pack_buf <= '0;
            buf_keep <= '0;
        end else begin
            if (accept) begin
                pack_buf <= buf_merged;
                buf_keep <= keep_merged;
                cnt      <= cnt + CNT_W'(1);
            end
            if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: doc/npu_oq_pack.md
Name: npu_oq_pack

Overview:
- Output requantize-and-pack stage. Sits directly downstream of the output scale stage `npu_sc_o`.
- Takes scaled signed M_LEN-bit results one per beat. Adds the output zero point, applies optional ReLU, and saturates to signed 8 bits.
- Packs PACK consecutive int8 results into one word for the output writeback path.
- Valid/ready on both sides. One registered output word.

Parameters:
- M_LEN, 32, width of incoming scaled data (matches npu_pkg::M_LEN).
- PACK, 4, int8 lanes per output word (power of two, >= 2).
- Q_LEN, 8, width of one quantized output lane (signed).

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  reset, asynchronous, active-high
- data_i  input  M_LEN  signed scaled result from npu_sc_o
- valid_i  input  1  data_i valid
- last_i  input  1  final element of tensor row; flushes partial word
- ready_o  output  1  stage can accept a beat this cycle
- zp_i  input  Q_LEN  signed output zero point, sampled per accepted beat
- relu_en_i  input  1  clamp below zero point, sampled per accepted beat
- data_o  output  PACK*Q_LEN  packed int8 word, lane 0 in LSBs
- keep_o  output  PACK  lane-valid mask, bit n = lane n holds data
- last_o  output  1  word closes a row
- valid_o  output  1  data_o/keep_o/last_o valid
- ready_i  input  1  downstream accepts word

Behaviour:
- Reset (async assert on rst_i high):
  - data_o=0, keep_o=0, last_o=0, valid_o=0.
  - Lane counter=0, pack buffer=0, buffer keep=0.
  - A partial word in flight is discarded.
  - Release is synchronous to clk_i; first accept is possible in the first cycle after release.
- Handshake:
  - Beat accepted when valid_i && ready_o.
  - Word transferred when valid_o && ready_i.
  - ready_o = !valid_o || ready_i. This is a combinational path from ready_i by design.
  - data_o/keep_o/last_o are held stable while valid_o && !ready_i.
- Per-beat arithmetic (combinational, on accept):
  - sum = sign-extended data_i + sign-extended zp_i, computed at M_LEN+1 bits with no overflow.
  - If relu_en_i: sum = max(sum, zp_i).
  - q = clamp(sum, -2^(Q_LEN-1), 2^(Q_LEN-1)-1), i.e. [-128, 127] at default.
- Packing:
  - Accepted q is written into pack buffer lane[cnt] and keep bit cnt is set.
  - Word closes when cnt==PACK-1 or last_i=1 on that beat.
  - On close: pack buffer, with the current lane merged, is loaded into the output register the same edge, and valid_o=1 next cycle.
  - last_o = last_i of the closing beat.
  - After close: cnt=0, buffer and keep cleared.
  - Otherwise cnt increments.
- Latency: closing beat accepted at edge N -> valid_o high after edge N (visible in cycle N+1).
- Throughput: one beat per cycle sustained when ready_i=1. One word per PACK beats.
- Partial flush: unfilled lanes in data_o are 0; keep_o shows only the filled lanes.
  - last_i with cnt==0 gives keep_o=0001 (PACK=4).
- Simultaneous events:
  - Output word draining (ready_i=1) in the same cycle a new word closes: new word loads, valid_o stays 1, no bubble.
  - Non-closing beats are accepted whenever ready_o=1. The buffer never overflows because a closing beat needs ready_o.
- Backpressure: ready_i=0 with valid_o=1 forces ready_o=0. The upstream beat and the buffer are held.
- zp_i/relu_en_i may change between beats. Each lane uses the values sampled on its own accept.
- valid_o never deasserts without a transfer or reset.

Test Plan:
- Pack basic (PACK=4, zp=0, relu off): data 1,2,3,4 on 4 consecutive cycles, ready_i=1 -> one word data_o=0x04030201, keep=1111, last_o=0, valid_o one cycle after 4th beat.
- Saturation + zero point: zp=-5, data 200, -300, 10, -1 -> lanes 127, -128(0x80), 5, -6(0xFA); data_o=0xFA0580_7F (0xFA05807F).
- ReLU: zp=3, relu on, data -10, 0, 7, -1 -> lanes 3,3,10,3 -> data_o=0x030A0303.
- Partial flush: beats 9, 8 with last_i=1 on 2nd -> data_o=0x00000809, keep=0011, last_o=1; next word starts at lane 0.
- Backpressure: ready_i=0 for 5 cycles while word pending and 3 more beats offered -> ready_o=0 during stall, data_o stable, no beat lost, words emitted in order after release; back-to-back words with ready_i=1 produce no idle cycle.
- Reset mid-word: 2 beats accepted, rst_i pulsed asynchronously between edges -> valid_o=0 and keep_o=0 immediately; next 4 beats form a clean word with keep=1111.
